alu_mul_sequencer: RTL

//  Owns the ALU operand/opcode ports in the execute stage. Idle: passes the pipeline's

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/alu_mul_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
// Word width and ALU opcode encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Execute-stage ALU port owner.
// Passes pipeline operands through, or borrows the ALU for shift-add multiply.
module alu_mul_sequencer
  import cpu_types_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] ex_portA,
  input  logic [WIDTH-1:0] ex_portB,
  input  aluop_t           ex_aluop,
  input  logic             mul_start,
  output logic [WIDTH-1:0] alu_portA,
  output logic [WIDTH-1:0] alu_portB,
  output aluop_t           alu_aluop,
  input  logic [WIDTH-1:0] alu_out,
  output logic             mul_busy,
  output logic             mul_done,
  output logic [WIDTH-1:0] mul_result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] acc, mcand, mplier, res_q;
  logic [CW-1:0]    count;
  logic             last;

  // last step: bit WIDTH-1 consumed, or no set multiplier bits remain
  always_comb begin
    last = (count == CW'(WIDTH - 1)) ||
           (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));
  end

  always_comb begin
    state_n   = state;
    alu_portA = ex_portA;
    alu_portB = ex_portB;
    alu_aluop = ex_aluop;
    unique case (state)
      IDLE: begin
        if (mul_start)
          state_n = (ex_portB == '0) ? DONE : RUN;
      end
      RUN: begin
        alu_portA = acc;
        alu_portB = mcand;
        alu_aluop = ALU_ADD;
        if (last)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      res_q  <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (mul_start) begin
            mcand  <= ex_portA;
            mplier <= ex_portB;
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          if (mplier[0])
            acc <= alu_out;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
        end
        DONE: res_q <= acc;
        default: ;
      endcase
    end
  end

  assign mul_busy = (state != IDLE);
  assign mul_done = (state == DONE);
  // acc is final in DONE, so expose it alongside the pulse
  assign mul_result = (state == DONE) ? acc : res_q;

endmodule
